fpnew_opgroup_out_arb: RTL and testbench
========================================

Name: fpnew_opgroup_out_arb

Overview:
- Sits directly downstream of the per-format slices of one operation group; collects their result streams.
- Selects one valid slice per cycle by round-robin and forwards its result, status, extension bit and tag through a single registered output stage to the FPU output mux.
- Adds one cycle of latency and sustains full throughput: one result per cycle when downstream is ready.

Parameters:
- NumInputs, 4, number of format slices feeding the arbiter (>=1).
- Width, 64, result width in bits; equals slice result width.
- TagWidth, 1, width of the tag carried with each result.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  discards the held output and blocks acceptance this cycle.
- slice_result_i  in  NumInputs x Width  per-slice result.
- slice_status_i  in  NumInputs x 5  per-slice status {NV,DZ,OF,UF,NX}.
- slice_ext_bit_i  in  NumInputs  per-slice extension bit.
- slice_tag_i  in  NumInputs x TagWidth  per-slice tag.
- slice_valid_i  in  NumInputs  per-slice result valid.
- slice_ready_o  out  NumInputs  per-slice ready; at most one high per cycle.
- slice_busy_i  in  NumInputs  per-slice in-flight indication.
- result_o  out  Width  registered result.
- status_o  out  5  registered status.
- extension_bit_o  out  1  registered extension bit.
- tag_o  out  TagWidth  registered tag.
- out_valid_o  out  1  output register holds a result.
- out_ready_i  in  1  downstream accepts the output.
- busy_o  out  1  any slice busy, or output register full.

Behaviour:
- Reset (rst_i high, asynchronous):
  - out_valid_o=0; result_o, status_o, extension_bit_o, tag_o = 0.
  - Priority pointer = 0.
- Output register free (can_load) when out_valid_o=0 or out_ready_i=1.
- Grant: when can_load=1 and flush_i=0, grant the first valid slice found scanning cyclically from the pointer.
  - slice_ready_o[g]=1 for the granted slice g only.
  - All slice_ready_o are 0 when there is no grant.
  - slice_ready_o depends combinationally on slice_valid_i and out_ready_i; there is no path from slice_ready_o to slice_valid_i.
- On a grant (handshake on slice g):
  - Output register loads slice g's result, status, ext bit and tag; out_valid_o=1 next cycle.
  - Pointer becomes (g+1) mod NumInputs.
- Pointer is unchanged when there is no grant.
- Output handshake with no grant that cycle: out_valid_o & out_ready_i clears out_valid_o.
- Simultaneous output drain and new grant: register reloads; out_valid_o stays 1 (back-to-back, no bubble).
- Output stability: while out_valid_o=1 and out_ready_i=0, all outputs hold their values and no slice is granted.
- Latency: slice handshake in cycle N makes the result visible on result_o in cycle N+1.
- flush_i=1:
  - out_valid_o=0 next cycle; all slice_ready_o=0 this cycle.
  - Pointer unchanged; data registers may keep stale values.
  - Flush takes priority over a simultaneous out_ready_i or grant.
- busy_o = (|slice_busy_i) | out_valid_o; combinational.
- NumInputs=1: pointer is constant 0; behaves as a plain pipeline register.
- Status and data are passed unmodified; no merging across slices.

Test Plan:
- Reset then idle: rst_i pulse mid-stream with out_valid_o=1 -> out_valid_o=0 and result_o=0 immediately (asynchronous); pointer=0; after release, first grant goes to the lowest valid index.
- Single slice, out_ready_i=1: slice 2 presents result 0x3FF0000000000000, status 5'b00001, tag 1 -> slice_ready_o=4'b0100 that cycle; next cycle result_o=0x3FF0000000000000, status_o=5'b00001, tag_o=1, out_valid_o=1.
- Round-robin fairness: all four slices valid continuously, out_ready_i=1 -> grants 0,1,2,3,0,1 in successive cycles; out_valid_o high every cycle after the first.
- Backpressure: out_valid_o=1 holding 0xAA, out_ready_i=0 for 3 cycles while slices 0 and 1 are valid -> slice_ready_o=0, result_o stays 0xAA; when out_ready_i=1, the same cycle grants the next slice by pointer and the next cycle shows its data.
- Flush: out_valid_o=1, flush_i=1 together with out_ready_i=1 and slice 1 valid -> slice_ready_o=0; next cycle out_valid_o=0; the following cycle without flush grants slice 1.
- Busy: slice_busy_i=4'b0000 with out_valid_o=1 -> busy_o=1; after drain -> busy_o=0; slice_busy_i=4'b1000 -> busy_o=1.

Source files
------------

// File: rtl/fpnew_opgroup_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : fpnew_opgroup_out_arb
// Purpose  : Round-robin arbiter that collects per-format slice results of one
//            operation group into a single registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module fpnew_opgroup_out_arb #(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned Width     = 64,
  parameter int unsigned TagWidth  = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NumInputs-1:0][Width-1:0]      slice_result_i,
  input  logic [NumInputs-1:0][4:0]            slice_status_i,
  input  logic [NumInputs-1:0]                 slice_ext_bit_i,
  input  logic [NumInputs-1:0][TagWidth-1:0]   slice_tag_i,
  input  logic [NumInputs-1:0]                 slice_valid_i,
  output logic [NumInputs-1:0]                 slice_ready_o,
  input  logic [NumInputs-1:0]                 slice_busy_i,
  output logic [Width-1:0]                     result_o,
  output logic [4:0]                           status_o,
  output logic                                 extension_bit_o,
  output logic [TagWidth-1:0]                  tag_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o
);

  localparam int unsigned PTR_W = (NumInputs > 1) ? $clog2(NumInputs) : 1;

  logic             can_load;
  logic             found;
  logic             grant;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr;

  // The output register can take a new result when empty or being drained.
  assign can_load = ~out_valid_o | out_ready_i;
  assign grant    = found & can_load & ~flush_i;
  assign busy_o   = (|slice_busy_i) | out_valid_o;

  // Find the first valid slice scanning cyclically from the priority pointer.
  always_comb begin
    int unsigned idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      idx = (int'(ptr) + i) % NumInputs;
      if (!found && slice_valid_i[idx]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  // One-hot ready toward the granted slice only.
  always_comb begin
    slice_ready_o = '0;
    if (grant) slice_ready_o[gnt_idx] = 1'b1;
  end

  generate
    if (NumInputs > 1) begin : g_rr_ptr
      // Advance the pointer past the slice that was just served.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ptr <= '0;
        end else if (grant) begin
          ptr <= (int'(gnt_idx) == NumInputs - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
      end
    end else begin : g_single_ptr
      assign ptr = '0;
    end
  endgenerate

  // Output stage: flush wins, then a new grant, then a plain drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o     <= 1'b0;
      result_o        <= '0;
      status_o        <= '0;
      extension_bit_o <= 1'b0;
      tag_o           <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (grant) begin
      out_valid_o     <= 1'b1;
      result_o        <= slice_result_i[gnt_idx];
      status_o        <= slice_status_i[gnt_idx];
      extension_bit_o <= slice_ext_bit_i[gnt_idx];
      tag_o           <= slice_tag_i[gnt_idx];
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpnew_opgroup_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpnew_opgroup_out_arb
// Purpose  : Directed self-checking bench for the op-group output arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpnew_opgroup_out_arb;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [3:0][63:0]  s_result;
  logic [3:0][4:0]   s_status;
  logic [3:0]        s_ext;
  logic [3:0][0:0]   s_tag;
  logic [3:0]        s_valid;
  logic [3:0]        s_ready;
  logic [3:0]        s_busy;
  logic [63:0]       result;
  logic [4:0]        status;
  logic              ext_bit;
  logic [0:0]        tag;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  fpnew_opgroup_out_arb #(
    .NumInputs(4), .Width(64), .TagWidth(1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .slice_result_i (s_result),
    .slice_status_i (s_status),
    .slice_ext_bit_i(s_ext),
    .slice_tag_i    (s_tag),
    .slice_valid_i  (s_valid),
    .slice_ready_o  (s_ready),
    .slice_busy_i   (s_busy),
    .result_o       (result),
    .status_o       (status),
    .extension_bit_o(ext_bit),
    .tag_o          (tag),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; s_valid = '0; s_busy = '0; out_ready = 1'b0;
    s_result = '0; s_status = '0; s_ext = '0; s_tag = '0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (result !== 64'd0 || status !== 5'd0 || tag !== 1'b0 || ext_bit !== 1'b0) begin
      n_fail++; $display("FAIL reset_data got %h/%b/%b/%b want 0", result, status, tag, ext_bit);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    s_valid = 4'b0100; s_result[2] = 64'h3FF0000000000000; s_status[2] = 5'b00001;
    s_tag[2] = 1'b1; s_ext[2] = 1'b1; out_ready = 1'b1;
    #2;
    n_checks++;
    if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", s_ready); end
    tick();
    s_valid = '0;
    n_checks++;
    if (result !== 64'h3FF0000000000000 || status !== 5'b00001 || tag !== 1'b1 || ext_bit !== 1'b1) begin
      n_fail++; $display("FAIL single_data got %h/%b/%b/%b want 3ff0000000000000/00001/1/1", result, status, tag, ext_bit);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    s_valid = 4'b0010; s_result[1] = 64'h55; out_ready = 1'b1;
    tick();
    s_valid = '0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 64'h55) begin
      n_fail++; $display("FAIL mid_load got %b/%h want 1/55", out_valid, result);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 64'd0) begin
      n_fail++; $display("FAIL async_reset got %b/%h want 0/0", out_valid, result);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) s_result[i] = 64'h100 + 64'(i);
    s_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      n_checks++;
      if (s_ready !== (4'b0001 << exp_g[k])) begin
        n_fail++; $display("FAIL rr_ready[%0d] got %b want slice %0d", k, s_ready, exp_g[k]);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || result !== 64'h100 + 64'(exp_g[k])) begin
        n_fail++; $display("FAIL rr_data[%0d] got %b/%h want 1/%h", k, out_valid, result, 64'h100 + 64'(exp_g[k]));
      end
    end
    s_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    // Pointer sits at 2: slice 3 is granted next and the pointer wraps to 0.
    s_valid = 4'b1000; s_result[3] = 64'hAA; out_ready = 1'b1;
    tick();
    s_valid = 4'b0011; s_result[0] = 64'h10; s_result[1] = 64'h11; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++;
      if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0000", k, s_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || result !== 64'hAA) begin
        n_fail++; $display("FAIL bp_hold[%0d] got %b/%h want 1/aa", k, out_valid, result);
      end
    end
    out_ready = 1'b1;
    #2;
    n_checks++;
    if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready got %b want 0001", s_ready); end
    tick();
    s_valid = '0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 64'h10) begin
      n_fail++; $display("FAIL bp_release_data got %b/%h want 1/10", out_valid, result);
    end
  endtask

  task automatic test_flush();
    // Pointer is 1; if flush wrongly moved it, slice 0 would win afterwards.
    s_valid = 4'b0011; s_result[1] = 64'h21; flush = 1'b1; out_ready = 1'b1;
    #2;
    n_checks++;
    if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL flush_ready got %b want 0000", s_ready); end
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
    #1;
    n_checks++;
    if (s_ready !== 4'b0010) begin n_fail++; $display("FAIL flush_regrant got %b want 0010", s_ready); end
    tick();
    s_valid = '0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 64'h21) begin
      n_fail++; $display("FAIL flush_data got %b/%h want 1/21", out_valid, result);
    end
  endtask

  task automatic test_busy();
    s_busy = 4'b0000;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_full got %b want 1", busy); end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_drained got %b/%b want 0/0", out_valid, busy);
    end
    s_busy = 4'b1000;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_slice got %b want 1", busy); end
    s_busy = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midstream();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
